// File: rtl/record_serializer.sv
// record_serializer: buffers 47-bit timestamp records in a FIFO and streams each one as three 16-bit words.
// Define RECORD_SERIALIZER_LOST_COUNT_EN to add a saturating 16-bit lost_count output.
module record_serializer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_rdy,
  input  logic [46:0]              in_data,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef RECORD_SERIALIZER_LOST_COUNT_EN
  ,
  output logic [15:0]              lost_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  logic [46:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [46:0]      rec_r;
  state_t           state_r;
  logic [15:0]      out_data_r;
  logic             out_valid_r;
  logic             overflow_r;

  state_t           state_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [46:0]      rec_s;
  logic [15:0]      out_data_s;

  // Next-state, pop decision and word selection; clear forces IDLE with no pop.
  always_comb begin
    state_s    = state_r;
    pop_s      = 1'b0;
    if (clear) begin
      state_s = IDLE;
      pop_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != {CNT_W{1'b0}}) begin
            state_s = W0;
            pop_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        W0: begin
          if (out_ready) state_s = W1;
          else           state_s = W0;
        end
        W1: begin
          if (out_ready) state_s = W2;
          else           state_s = W1;
        end
        W2: begin
          if (!out_ready) begin
            state_s = W2;
          end else if (count_r != {CNT_W{1'b0}}) begin
            state_s = W0;
            pop_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
          pop_s   = 1'b0;
        end
      endcase
    end

    // A full FIFO still accepts a record when the head leaves on the same edge.
    push_s = in_rdy && !clear && ((count_r < CNT_W'(DEPTH)) || pop_s);
    drop_s = in_rdy && !clear && !push_s;

    if (pop_s) rec_s = mem_r[rd_ptr_r];
    else       rec_s = rec_r;

    case (state_s)
      W0:      out_data_s = {1'b1, rec_s[46:32]};
      W1:      out_data_s = rec_s[31:16];
      W2:      out_data_s = rec_s[15:0];
      default: out_data_s = 16'h0000;
    endcase
  end

  // Record storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Serializer state, holding register and registered output word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rec_r       <= 47'h0;
      out_data_r  <= 16'h0000;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      rec_r       <= rec_s;
      out_data_r  <= out_data_s;
      out_valid_r <= (state_s != IDLE);
    end
  end

  // Sticky drop indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow_r <= 1'b0;
    else if (clear)   overflow_r <= 1'b0;
    else if (drop_s)  overflow_r <= 1'b1;
    else              overflow_r <= overflow_r;
  end

`ifdef RECORD_SERIALIZER_LOST_COUNT_EN
  logic [15:0] lost_count_r;

  // Saturating count of dropped records.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               lost_count_r <= 16'h0000;
    else if (clear)                             lost_count_r <= 16'h0000;
    else if (drop_s && lost_count_r != 16'hFFFF) lost_count_r <= lost_count_r + 16'h0001;
    else                                        lost_count_r <= lost_count_r;
  end

  assign lost_count = lost_count_r;
`endif

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_record_serializer.sv
// Scoreboard bench for record_serializer: a queue-based reference model predicts words and status,
// a negedge monitor compares them against the DUT.
module tb_record_serializer;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_rdy = 1'b0;
  logic [46:0]      in_data = 47'h0;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic             out_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
`ifdef RECORD_SERIALIZER_LOST_COUNT_EN
  logic [15:0]      lost_count;
`endif

  record_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_rdy(in_rdy), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow)
`ifdef RECORD_SERIALIZER_LOST_COUNT_EN
    , .lost_count(lost_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] w; logic [15:0] m; bit first; } exp_t;
  exp_t        exp_q[$];
  logic [46:0] mq[$];
  int          left = 0;
  bit          m_ovf = 1'b0;
  int          m_lost = 0;
  bit          m_pop, m_room;
  int          checks = 0, errors = 0, rec_out = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: pending-record queue plus words left in the record on the wire.
  initial forever begin
    @(posedge clk);
    if (!reset_n || clear) begin
      mq.delete(); exp_q.delete(); left = 0; m_ovf = 1'b0; m_lost = 0;
    end else begin
      if (left > 0 && out_ready) left--;
      m_pop  = (left == 0) && (mq.size() > 0);
      m_room = (mq.size() < DEPTH) || m_pop;
      if (m_pop) begin
        void'(mq.pop_front());
        left = 3;
      end
      if (in_rdy) begin
        if (m_room) begin
          mq.push_back(in_data);
          exp_q.push_back('{w: {1'b1, in_data[46:32]}, m: 16'hFFFF, first: 1'b1});
          exp_q.push_back('{w: in_data[31:16], m: 16'hFFFF, first: 1'b0});
          exp_q.push_back('{w: in_data[15:0], m: 16'h7FFF, first: 1'b0});
        end else begin
          m_ovf = 1'b1;
          if (m_lost < 65535) m_lost++;
        end
      end
    end
  end

  // Monitor: status against the model every cycle, words against the scoreboard on handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      check("out_valid", out_valid, left > 0);
      check("fifo_count", fifo_count, mq.size());
      check("overflow", overflow, m_ovf);
`ifdef RECORD_SERIALIZER_LOST_COUNT_EN
      check("lost_count", lost_count, m_lost);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data & e.m, e.w & e.m);
          if (e.first) rec_out++;
        end
      end
    end
  end

  initial begin
    int r0;
    int waited;
    step(2);

    // Single strobe on the first edge after reset release.
    reset_n = 1'b1; out_ready = 1'b1; in_data = 47'h1234_5678_9ABC; in_rdy = 1'b1;
    step(1); in_rdy = 1'b0;
    step(1); check("w0_word", {out_valid, out_data}, {1'b1, 16'h9234});
    step(1); check("w1_word", {out_valid, out_data}, {1'b1, 16'h5678});
    step(1); check("w2_word", {out_valid, out_data}, {1'b1, 16'h9ABC});
    step(1); check("idle_after", out_valid, 1'b0);

    // Backpressure in W1.
    in_rdy = 1'b1; step(1); in_rdy = 1'b0;
    step(2); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1); check("hold_w1", {out_valid, out_data}, {1'b1, 16'h5678});
    end
    out_ready = 1'b1;
    step(1); check("resume_w2", {out_valid, out_data}, {1'b1, 16'h9ABC});
    step(2);

    // Overflow: ten strobes with the host stalled.
    out_ready = 1'b0; r0 = rec_out;
    for (int i = 0; i < 10; i++) begin
      in_data = {15'($urandom), 32'($urandom)}; in_rdy = 1'b1; step(1);
    end
    in_rdy = 1'b0;
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1'b1);
`ifdef RECORD_SERIALIZER_LOST_COUNT_EN
    check("ovf_lost", lost_count, 16'h0001);
`endif
    out_ready = 1'b1; step(40);
    check("ovf_emitted", rec_out - r0, 9);

    // Full FIFO accepts a strobe on the W2->W0 pop edge.
    clear = 1'b1; step(1); clear = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_data = {15'($urandom), 32'($urandom)}; in_rdy = 1'b1; step(1);
    end
    in_rdy = 1'b0;
    check("full_count", fifo_count, 8);
    out_ready = 1'b1; step(2);
    in_data = 47'h7FFF_0000_1111; in_rdy = 1'b1; step(1); in_rdy = 1'b0;
    check("full_pop_count", fifo_count, 8);
    check("full_pop_ovf", overflow, 1'b0);
    step(40);

    // Clear mid-record with three records queued.
    out_ready = 1'b0; in_rdy = 1'b1; step(4); in_rdy = 1'b0;
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    clear = 1'b1; step(1); clear = 1'b0;
    check("clr_state", {out_valid, fifo_count, overflow}, {1'b0, CNT_W'(0), 1'b0});
    out_ready = 1'b1; in_data = 47'h0ABC_DEAD_BEEF; in_rdy = 1'b1; step(1); in_rdy = 1'b0;
    step(1); check("clr_new_w0", {out_valid, out_data}, {1'b1, 16'h8ABC});
    step(4);

    // Reset mid-record drops out_valid immediately.
    in_rdy = 1'b1; step(1); in_rdy = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin step(1); waited++; end
    check("rst_wait_valid", out_valid, 1'b1);
    out_ready = 1'b0; reset_n = 1'b0; #1;
    check("rst_async", {out_valid, out_data, fifo_count, overflow}, {1'b0, 16'h0000, CNT_W'(0), 1'b0});
    step(2); reset_n = 1'b1;

    // Randomized phases with varying load and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      in_data   = {15'($urandom), 32'($urandom)};
      in_rdy    = ($urandom_range(0, 2) == 0);
      out_ready = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 199) == 0);
      step(1);
    end
    in_rdy = 1'b0; clear = 1'b0; out_ready = 1'b1;
    step(60);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
